axis_stim_sched: RTL

//  Scheduler for the axis_stim_syn AXI-Stream stimulus generator. Runs a programmed schedule of

---
 rtl/axis_stim_pkg.sv | 15 +
 rtl/axis_stim_sched_cnt_dn.sv | 34 +++
 rtl/axis_stim_sched.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axis_stim_pkg.sv
// Shared types and default widths for the axis_stim burst scheduler.
package axis_stim_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int GAP_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } sched_state_t;

endpackage

// File: rtl/axis_stim_sched_cnt_dn.sv
// Loadable saturating down-counter with a zero flag; load takes priority over decrement.
module cnt_dn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/axis_stim_sched.sv
// Burst scheduler driving axis_stim_syn en/clr/cycle/cont; packets counted on tlast handshakes.
// Optional RUN-state watchdog enabled by defining AXIS_STIM_SCHED_WDOG_EN.
module axis_stim_sched
  import axis_stim_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
`ifdef AXIS_STIM_SCHED_WDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_pkts,
  input  logic [CNT_W-1:0] cfg_bursts,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             cfg_cycle,
  input  logic             cfg_cont,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             stim_en,
  output logic             stim_clr,
  output logic             stim_cycle,
  output logic             stim_cont,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             wdog_err
);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cfg_pkts_q, cfg_pkts_d;
  logic [CNT_W-1:0] cfg_bursts_q, cfg_bursts_d;
  logic [GAP_W-1:0] cfg_gap_q, cfg_gap_d;
  logic             cfg_cycle_q, cfg_cycle_d;
  logic             cfg_cont_q, cfg_cont_d;
  logic             aborted_q, aborted_d;
  logic             pkt_hs, start_acc, gap_load, gap_zero, wdog_trip;

  assign pkt_hs    = mon_tvalid & mon_tready & mon_tlast;
  assign start_acc = (state_q == IDLE) && start && !abort;

  always_comb begin
    state_d      = state_q;
    pkt_cnt_d    = pkt_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    cfg_pkts_d   = cfg_pkts_q;
    cfg_bursts_d = cfg_bursts_q;
    cfg_gap_d    = cfg_gap_q;
    cfg_cycle_d  = cfg_cycle_q;
    cfg_cont_d   = cfg_cont_q;
    aborted_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          cfg_pkts_d   = cfg_pkts;
          cfg_bursts_d = cfg_bursts;
          cfg_gap_d    = cfg_gap;
          cfg_cycle_d  = cfg_cycle;
          cfg_cont_d   = cfg_cont;
          pkt_cnt_d    = '0;
          burst_cnt_d  = '0;
          state_d      = CLR;
        end
      end
      CLR: begin
        pkt_cnt_d = '0;
        state_d   = (cfg_pkts_q == '0) ? DONE : RUN;
      end
      RUN: begin
        if (pkt_hs) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          if (pkt_cnt_q == cfg_pkts_q - CNT_W'(1)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
            // a zero burst count never matches, so the schedule runs until abort
            if ((cfg_bursts_q != '0) && (burst_cnt_d == cfg_bursts_q)) begin
              state_d = DONE;
            end else if (cfg_gap_q == '0) begin
              state_d = CLR;
            end else begin
              state_d = GAP;
            end
          end
        end else if (wdog_trip) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d = CLR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pkt_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      cfg_pkts_q   <= '0;
      cfg_bursts_q <= '0;
      cfg_gap_q    <= '0;
      cfg_cycle_q  <= 1'b0;
      cfg_cont_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_cnt_q    <= pkt_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      cfg_pkts_q   <= cfg_pkts_d;
      cfg_bursts_q <= cfg_bursts_d;
      cfg_gap_q    <= cfg_gap_d;
      cfg_cycle_q  <= cfg_cycle_d;
      cfg_cont_q   <= cfg_cont_d;
      aborted_q    <= aborted_d;
    end
  end

  // loaded with gap-1 so GAP lasts exactly cfg_gap cycles (GAP is only entered with cfg_gap != 0)
  assign gap_load = (state_q == RUN) && (state_d == GAP);

  cnt_dn #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rstn     (rstn),
    .load     (gap_load),
    .en       (state_q == GAP),
    .load_val (cfg_gap_q - GAP_W'(1)),
    .zero     (gap_zero)
  );

`ifdef AXIS_STIM_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic beat, wd_zero, wdog_err_q;

  assign beat = mon_tvalid & mon_tready;

  // held at WDOG_CYCLES-1 outside RUN and on every beat; trips on the WDOG_CYCLES-th idle RUN cycle
  cnt_dn #(.W(WD_W)) u_wdog (
    .clk      (clk),
    .rstn     (rstn),
    .load     ((state_q != RUN) || beat),
    .en       (state_q == RUN),
    .load_val (WD_W'(WDOG_CYCLES - 1)),
    .zero     (wd_zero)
  );

  assign wdog_trip = (state_q == RUN) && wd_zero && !beat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wdog_err_q <= 1'b0;
    end else if (start_acc) begin
      wdog_err_q <= 1'b0;
    end else if (wdog_trip && !abort) begin
      wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  assign busy       = (state_q != IDLE);
  assign stim_clr   = (state_q == CLR);
  assign stim_en    = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign stim_cycle = busy & cfg_cycle_q;
  assign stim_cont  = busy & cfg_cont_q;
  assign aborted    = aborted_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign burst_cnt  = burst_cnt_q;

endmodule
